// File: rtl/color_hsv_pkg.sv
// Shared types and command encodings for the colour/HSV state machine.
package color_hsv_pkg;

   typedef enum logic [1:0] {
      PS_BLUE = 2'd0,
      PS_RED  = 2'd1,
      PS_HSV  = 2'd2
   } parent_state_t;

   typedef enum logic [1:0] {
      HS_IDLE = 2'd0,
      HS_HUE  = 2'd1,
      HS_SAT  = 2'd2,
      HS_VAL  = 2'd3
   } hsv_state_t;

   localparam int CMD_EXIT   = 0;
   localparam int CMD_TOGGLE = 1;
   localparam int CMD_HSV    = 2;
   localparam int CMD_HOLD   = 3;

   // HSV phase order; VAL wraps to HUE because IDLE is only an entry phase.
   function automatic hsv_state_t hsv_advance(input hsv_state_t s);
      hsv_state_t n;
      case (s)
         HS_IDLE: n = HS_HUE;
         HS_HUE:  n = HS_SAT;
         HS_SAT:  n = HS_VAL;
         HS_VAL:  n = HS_HUE;
         default: n = HS_IDLE;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/hsv_sub_fsm.sv
// HSV child phase register plus saturating dwell counter and timeout detect.
module hsv_sub_fsm
   import color_hsv_pkg::*;
#(
   parameter int HSV_TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       active,
   input  logic       hold,
   input  logic       exit,
   output hsv_state_t sub_state,
   output hsv_state_t sub_next,
   output logic       timeout_hit
);

   localparam int CNT_W = (HSV_TIMEOUT > 0) ? $clog2(HSV_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HSV_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   hsv_state_t       sub_r;
   hsv_state_t       sub_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic             timeout_hit_s;

   // Timeout fires only on an advancing cycle; an explicit exit takes priority.
   always_comb begin
      timeout_hit_s = 1'b0;
      if ((HSV_TIMEOUT != 0) && active && !hold && !exit) begin
         timeout_hit_s = (cnt_r == CNT_LAST);
      end else begin
         timeout_hit_s = 1'b0;
      end
   end

   // Next child phase and dwell count; outside HSV both sit at their idle values.
   always_comb begin
      sub_next_s = sub_r;
      cnt_next_s = cnt_r;
      if (!active) begin
         sub_next_s = HS_IDLE;
         cnt_next_s = '0;
      end else if (hold) begin
         sub_next_s = sub_r;
         cnt_next_s = cnt_r;
      end else if (exit || timeout_hit_s) begin
         sub_next_s = HS_IDLE;
         cnt_next_s = '0;
      end else begin
         sub_next_s = hsv_advance(sub_r);
         if (cnt_r != CNT_MAX) begin
            cnt_next_s = cnt_r + CNT_W'(1);
         end else begin
            cnt_next_s = cnt_r;
         end
      end
   end

   // Child phase and dwell counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sub_r <= HS_IDLE;
         cnt_r <= '0;
      end else begin
         sub_r <= sub_next_s;
         cnt_r <= cnt_next_s;
      end
   end

   assign sub_state   = sub_r;
   assign sub_next    = sub_next_s;
   assign timeout_hit = timeout_hit_s;

endmodule

// File: rtl/color_hsv_fsm.sv
// Parent colour FSM (BLUE/RED/HSV) with registered output and status pulses.
module color_hsv_fsm
   import color_hsv_pkg::*;
#(
   parameter int IN_WIDTH    = 2,
   parameter int OUT_WIDTH   = 2,
   parameter int BLUE_VAL    = 1,
   parameter int RED_VAL     = 2,
   parameter int HSV_BASE    = 2,
   parameter int HSV_TIMEOUT = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IN_WIDTH-1:0]  in,
   output logic [OUT_WIDTH-1:0] out,
   output logic [1:0]           state,
   output logic [1:0]           sub_state,
   output logic                 state_change,
   output logic                 timeout
);

   localparam logic [OUT_WIDTH-1:0] BLUE_O = OUT_WIDTH'(BLUE_VAL);
   localparam logic [OUT_WIDTH-1:0] RED_O  = OUT_WIDTH'(RED_VAL);
   localparam logic [OUT_WIDTH-1:0] HSV_O  = OUT_WIDTH'(HSV_BASE);

   parent_state_t        state_r;
   parent_state_t        state_next_s;
   logic [OUT_WIDTH-1:0] out_r;
   logic [OUT_WIDTH-1:0] out_next_s;
   logic                 state_change_r;
   logic                 timeout_r;
   logic                 cmd_exit_s;
   logic                 cmd_toggle_s;
   logic                 cmd_hsv_s;
   logic                 cmd_hold_s;
   logic                 hsv_active_s;
   logic                 timeout_hit_s;
   hsv_state_t           sub_cur_s;
   hsv_state_t           sub_next_s;
   logic [1:0]           sub_next_bits_s;

   // Full-width compares so that codes above 3 decode as NOP.
   assign cmd_exit_s   = (in == IN_WIDTH'(CMD_EXIT));
   assign cmd_toggle_s = (in == IN_WIDTH'(CMD_TOGGLE));
   assign cmd_hsv_s    = (in == IN_WIDTH'(CMD_HSV));
   assign cmd_hold_s   = (in == IN_WIDTH'(CMD_HOLD));
   assign hsv_active_s = (state_r == PS_HSV);

   hsv_sub_fsm #(
      .HSV_TIMEOUT (HSV_TIMEOUT)
   ) u_hsv_sub (
      .clk         (clk),
      .rst         (rst),
      .active      (hsv_active_s),
      .hold        (cmd_hold_s),
      .exit        (cmd_exit_s),
      .sub_state   (sub_cur_s),
      .sub_next    (sub_next_s),
      .timeout_hit (timeout_hit_s)
   );

   // Parent next-state decode; HOLD freezes every state.
   always_comb begin
      state_next_s = state_r;
      if (cmd_hold_s) begin
         state_next_s = state_r;
      end else begin
         case (state_r)
            PS_RED: begin
               if (cmd_toggle_s) begin
                  state_next_s = PS_BLUE;
               end else if (cmd_hsv_s) begin
                  state_next_s = PS_HSV;
               end else begin
                  state_next_s = PS_RED;
               end
            end
            PS_BLUE: begin
               if (cmd_toggle_s) begin
                  state_next_s = PS_RED;
               end else begin
                  state_next_s = PS_BLUE;
               end
            end
            PS_HSV: begin
               if (cmd_exit_s || timeout_hit_s) begin
                  state_next_s = PS_RED;
               end else begin
                  state_next_s = PS_HSV;
               end
            end
            default: state_next_s = PS_RED;
         endcase
      end
   end

   // Output value from the next state so the registered out tracks state exactly.
   always_comb begin
      sub_next_bits_s = sub_next_s;
      out_next_s      = RED_O;
      case (state_next_s)
         PS_BLUE: out_next_s = BLUE_O;
         PS_RED:  out_next_s = RED_O;
         PS_HSV:  out_next_s = HSV_O + OUT_WIDTH'(sub_next_bits_s);
         default: out_next_s = RED_O;
      endcase
   end

   // Parent state, output register and one-cycle status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r        <= PS_RED;
         out_r          <= RED_O;
         state_change_r <= 1'b0;
         timeout_r      <= 1'b0;
      end else begin
         state_r        <= state_next_s;
         out_r          <= out_next_s;
         state_change_r <= !cmd_hold_s && (state_next_s != state_r);
         timeout_r      <= timeout_hit_s;
      end
   end

   assign state        = state_r;
   assign sub_state    = sub_cur_s;
   assign out          = out_r;
   assign state_change = state_change_r;
   assign timeout      = timeout_r;

endmodule

// File: tb/tb_color_hsv_fsm.sv
// Self-checking bench: behavioural model compared every cycle, plus directed literal checks.
module tb_color_hsv_fsm;

   localparam int IW = 4;
   localparam int OW = 2;
   localparam int BV = 1;
   localparam int RV = 2;
   localparam int HB = 2;
   localparam int TO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [IW-1:0] in_s = '0;
   logic [OW-1:0] out_s;
   logic [1:0]    state_s;
   logic [1:0]    sub_state_s;
   logic          state_change_s;
   logic          timeout_s;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: parent 0=BLUE 1=RED 2=HSV, child phase index, cycles spent advancing in HSV.
   int m_parent = 1;
   int m_child  = 0;
   int m_dwell  = 0;
   int m_sc     = 0;
   int m_to     = 0;

   color_hsv_fsm #(
      .IN_WIDTH    (IW),
      .OUT_WIDTH   (OW),
      .BLUE_VAL    (BV),
      .RED_VAL     (RV),
      .HSV_BASE    (HB),
      .HSV_TIMEOUT (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in           (in_s),
      .out          (out_s),
      .state        (state_s),
      .sub_state    (sub_state_s),
      .state_change (state_change_s),
      .timeout      (timeout_s)
   );

   always #5 clk = ~clk;

   function automatic int model_out();
      int mod = 1 << OW;
      if (m_parent == 0) return BV % mod;
      if (m_parent == 1) return RV % mod;
      return (HB + m_child) % mod;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_parent = 1; m_child = 0; m_dwell = 0; m_sc = 0; m_to = 0;
   endtask

   task automatic model_step(input int cmd);
      int prev = m_parent;
      m_sc = 0;
      m_to = 0;
      if (cmd == 3) return;
      if (m_parent == 1) begin
         if (cmd == 1) m_parent = 0;
         else if (cmd == 2) begin
            m_parent = 2; m_child = 0; m_dwell = 0;
         end
      end else if (m_parent == 0) begin
         if (cmd == 1) m_parent = 1;
      end else begin
         if (cmd == 0) m_parent = 1;
         else if (TO != 0 && m_dwell == TO - 1) begin
            m_parent = 1; m_to = 1;
         end else begin
            m_child = (m_child == 3) ? 1 : m_child + 1;
            m_dwell++;
         end
         if (m_parent != 2) begin
            m_child = 0; m_dwell = 0;
         end
      end
      m_sc = (m_parent != prev) ? 1 : 0;
   endtask

   // Model update on the same events that move the DUT.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) model_reset();
         else model_step(int'(in_s));
      end
   end

   // Per-cycle comparison against the model, half a period away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         check("cyc_state", int'(state_s), m_parent);
         check("cyc_sub", int'(sub_state_s), m_child);
         check("cyc_out", int'(out_s), model_out());
         check("cyc_state_change", int'(state_change_s), m_sc);
         check("cyc_timeout", int'(timeout_s), m_to);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic cycle(input int cmd);
      @(negedge clk);
      in_s = IW'(cmd);
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string tag, input int st, input int sub, input int o,
                             input int sc, input int to);
      check({tag, "_state"}, int'(state_s), st);
      check({tag, "_sub"}, int'(sub_state_s), sub);
      check({tag, "_out"}, int'(out_s), o);
      check({tag, "_sc"}, int'(state_change_s), sc);
      check({tag, "_to"}, int'(timeout_s), to);
   endtask

   initial begin
      int r;
      int cmd;
      rst  = 1'b1;
      in_s = '0;
      repeat (2) @(posedge clk);
      #1;
      expect_now("reset", 1, 0, 2, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // RED stays RED on cmd 0 without a pulse.
      for (int i = 0; i < 3; i++) begin
         cycle(0);
         expect_now("red_stay", 1, 0, 2, 0, 0);
      end

      // Toggle to BLUE and back.
      cycle(1); expect_now("to_blue", 0, 0, 1, 1, 0);
      cycle(1); expect_now("to_red", 1, 0, 2, 1, 0);

      // HSV phase walk with OUT_WIDTH=2 wrap, then explicit exit.
      cycle(2); expect_now("hsv_enter", 2, 0, 2, 1, 0);
      cycle(4); expect_now("hsv_hue", 2, 1, 3, 0, 0);
      cycle(4); expect_now("hsv_sat", 2, 2, 0, 0, 0);
      cycle(4); expect_now("hsv_val", 2, 3, 1, 0, 0);
      cycle(4); expect_now("hsv_hue2", 2, 1, 3, 0, 0);
      cycle(0); expect_now("hsv_exit", 1, 0, 2, 1, 0);

      // Dwell timeout eight cycles after entry.
      cycle(2);
      for (int i = 0; i < 7; i++) begin
         cycle(4);
         check("to_pending_state", int'(state_s), 2);
         check("to_pending_to", int'(timeout_s), 0);
      end
      cycle(4); expect_now("to_fire", 1, 0, 2, 1, 1);
      cycle(0); expect_now("to_after", 1, 0, 2, 0, 0);

      // Exit command on the timeout cycle suppresses the timeout pulse.
      cycle(2);
      for (int i = 0; i < 7; i++) cycle(1);
      cycle(0); expect_now("exit_wins", 1, 0, 2, 1, 0);

      // HOLD freezes everything and delays the timeout.
      cycle(2);
      cycle(4);
      cycle(4);
      for (int i = 0; i < 5; i++) begin
         cycle(3);
         expect_now("hold", 2, 2, 0, 0, 0);
      end
      for (int i = 0; i < 5; i++) cycle(4);
      check("hold_late_state", int'(state_s), 2);
      cycle(4); expect_now("hold_to_fire", 1, 0, 2, 1, 1);

      // Asynchronous reset between edges while in HSV/SAT.
      cycle(2);
      cycle(4);
      cycle(4);
      check("pre_rst_sub", int'(sub_state_s), 2);
      #1;
      rst = 1'b1;
      #1;
      expect_now("async_rst", 1, 0, 2, 0, 0);
      @(negedge clk);
      #2;
      rst = 1'b0;
      cycle(2); expect_now("post_rst_enter", 2, 0, 2, 1, 0);
      cycle(0);

      // Out-of-range codes are NOP in RED and BLUE; HOLD in BLUE.
      cycle(9); expect_now("nop_red", 1, 0, 2, 0, 0);
      cycle(1);
      cycle(9); expect_now("nop_blue", 0, 0, 1, 0, 0);
      cycle(3); expect_now("hold_blue", 0, 0, 1, 0, 0);
      cycle(1);

      // Randomised traffic with occasional mid-cycle resets.
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 8)       cmd = 0;
         else if (r < 20) cmd = 1;
         else if (r < 40) cmd = 2;
         else if (r < 50) cmd = 3;
         else             cmd = $urandom_range(4, 15);
         cycle(cmd);
         if ($urandom_range(0, 299) == 0) begin
            #2;
            rst = 1'b1;
            @(negedge clk);
            #2;
            rst = 1'b0;
         end
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
